// File: rtl/esc_pkg.sv
// Shared definitions for the escape-mode receive controller: the FSM state
// encoding, the entry command bytes, and the trigger decode.
package esc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_LPDT      = 3'd2,
    ST_ULPS      = 3'd3,
    ST_WAIT_EXIT = 3'd4
  } esc_state_e;

  localparam logic [7:0] CMD_LPDT  = 8'hE1;
  localparam logic [7:0] CMD_ULPS  = 8'h1E;
  localparam logic [7:0] CMD_TRIG0 = 8'h62;
  localparam logic [7:0] CMD_TRIG1 = 8'h5D;
  localparam logic [7:0] CMD_TRIG2 = 8'h21;
  localparam logic [7:0] CMD_TRIG3 = 8'hA0;

  // An all-zero result means the byte is not a trigger command.
  function automatic logic [3:0] trig_decode(input logic [7:0] cmd);
    logic [3:0] onehot;
    case (cmd)
      CMD_TRIG0: onehot = 4'b0001;
      CMD_TRIG1: onehot = 4'b0010;
      CMD_TRIG2: onehot = 4'b0100;
      CMD_TRIG3: onehot = 4'b1000;
      default:   onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/esc_edge_sync.sv
// Two-flop synchroniser with a single-cycle rising-edge pulse on the
// synchronised value.
module esc_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/esc_rx_ctrl.sv
// Escape-mode receiver: decodes the entry command, then receives LPDT bytes,
// holds ULPS, or pulses a trigger / error until Escape Mode ends.
//
// state        | meaning
// ST_IDLE      | stop state, waiting for EscMode to rise
// ST_CMD       | shifting in the 8-bit entry command, MSB first
// ST_LPDT      | receiving data bytes, LSB first
// ST_ULPS      | ultra-low-power state, bit strobes ignored
// ST_WAIT_EXIT | trigger or bad command seen, waiting for EscMode low
module esc_rx_ctrl
  import esc_pkg::*;
(
  input  logic       Clk,
  input  logic       RstN,
  input  logic       EscMode,
  input  logic       RxClkEsc,
  input  logic       EscBit,
  output logic       RecEn,
  output logic       RxLpdtEsc,
  output logic       RxUlpsEsc,
  output logic [3:0] RxTriggerEsc,
  output logic [7:0] RxDataEsc,
  output logic       RxValidEsc,
  output logic       ErrEsc,
  output logic       ErrSyncEsc
);

  esc_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [3:0] trig_q, trig_d;
  logic       err_q, err_d;
  logic       err_sync_q, err_sync_d;
  logic       esc_mode_q;
  logic [1:0] bit_sync_q;

  logic       strobe;
  logic       bit_s;
  logic [7:0] cmd_byte;
  logic [7:0] lpdt_byte;

  esc_edge_sync u_clk_sync (
    .clk_i   (Clk),
    .rst_n_i (RstN),
    .d_i     (RxClkEsc),
    .rise_o  (strobe)
  );

  // Same two-stage latency as the clock path, so the bit lines up with its strobe.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) bit_sync_q <= 2'b00;
    else       bit_sync_q <= {bit_sync_q[0], EscBit};
  end

  assign bit_s     = bit_sync_q[1];
  assign cmd_byte  = {shift_q[6:0], bit_s};
  assign lpdt_byte = {bit_s, shift_q[7:1]};

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      trig_q     <= 4'b0000;
      err_q      <= 1'b0;
      err_sync_q <= 1'b0;
      esc_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      trig_q     <= trig_d;
      err_q      <= err_d;
      err_sync_q <= err_sync_d;
      esc_mode_q <= EscMode;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    trig_d     = 4'b0000;
    err_d      = 1'b0;
    err_sync_d = 1'b0;

    // Leaving Escape Mode wins over any strobe landing in the same cycle.
    if ((state_q != ST_IDLE) && !EscMode) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      err_sync_d = (state_q == ST_LPDT) && (bit_cnt_q != 3'd0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (EscMode && !esc_mode_q) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
          end
        end
        ST_CMD: begin
          if (strobe) begin
            shift_d   = cmd_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (cmd_byte == CMD_LPDT) begin
                state_d = ST_LPDT;
              end else if (cmd_byte == CMD_ULPS) begin
                state_d = ST_ULPS;
              end else begin
                trig_d  = trig_decode(cmd_byte);
                err_d   = (trig_decode(cmd_byte) == 4'b0000);
                state_d = ST_WAIT_EXIT;
              end
            end
          end
        end
        ST_LPDT: begin
          if (strobe) begin
            shift_d   = lpdt_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d  = lpdt_byte;
              valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RecEn follows EscMode but must read 0 while reset is held.
  assign RecEn        = EscMode & RstN;
  assign RxLpdtEsc    = (state_q == ST_LPDT);
  assign RxUlpsEsc    = (state_q == ST_ULPS);
  assign RxTriggerEsc = trig_q;
  assign RxDataEsc    = data_q;
  assign RxValidEsc   = valid_q;
  assign ErrEsc       = err_q;
  assign ErrSyncEsc   = err_sync_q;

endmodule

// File: tb/tb_esc_rx_ctrl.sv
// Self-checking bench for esc_rx_ctrl: entry-command table plus LPDT, ULPS,
// trigger, partial-byte and mid-byte reset sequences.
module tb_esc_rx_ctrl;

  logic       Clk = 1'b0;
  logic       RstN;
  logic       EscMode;
  logic       RxClkEsc;
  logic       EscBit;
  logic       RecEn;
  logic       RxLpdtEsc;
  logic       RxUlpsEsc;
  logic [3:0] RxTriggerEsc;
  logic [7:0] RxDataEsc;
  logic       RxValidEsc;
  logic       ErrEsc;
  logic       ErrSyncEsc;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0;
  int err_cnt = 0;
  int errsync_cnt = 0;
  int trig_cycles = 0;
  logic [3:0] trig_last = 4'b0000;
  logic strobe_prev = 1'b0;
  logic [7:0] exp_q[$];

  esc_rx_ctrl dut (
    .Clk          (Clk),
    .RstN         (RstN),
    .EscMode      (EscMode),
    .RxClkEsc     (RxClkEsc),
    .EscBit       (EscBit),
    .RecEn        (RecEn),
    .RxLpdtEsc    (RxLpdtEsc),
    .RxUlpsEsc    (RxUlpsEsc),
    .RxTriggerEsc (RxTriggerEsc),
    .RxDataEsc    (RxDataEsc),
    .RxValidEsc   (RxValidEsc),
    .ErrEsc       (ErrEsc),
    .ErrSyncEsc   (ErrSyncEsc)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: pop expected bytes as valid pulses appear, and count pulses.
  always @(negedge Clk) begin
    if (RxValidEsc) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_data: unexpected valid with data %0h", RxDataEsc);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (RxDataEsc !== e) begin
          errors++;
          $display("FAIL rx_data: got %0h expected %0h", RxDataEsc, e);
        end
      end
      checks++;
      if (!strobe_prev) begin
        errors++;
        $display("FAIL valid_timing: got valid without strobe one cycle earlier, expected strobe");
      end
    end
    if (ErrEsc) err_cnt++;
    if (ErrSyncEsc) errsync_cnt++;
    if (RxTriggerEsc != 4'b0000) begin
      trig_cycles++;
      trig_last = RxTriggerEsc;
    end
    strobe_prev = dut.strobe;
  end

  task automatic send_bit(input logic b);
    @(negedge Clk);
    EscBit = b;
    RxClkEsc = 1'b0;
    repeat (3) @(negedge Clk);
    RxClkEsc = 1'b1;
    repeat (4) @(negedge Clk);
    RxClkEsc = 1'b0;
  endtask

  task automatic send_msb(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_lsb(input logic [7:0] v);
    exp_q.push_back(v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic enter(input logic [7:0] cmd);
    @(negedge Clk);
    EscMode = 1'b1;
    repeat (3) @(negedge Clk);
    send_msb(cmd);
    repeat (3) @(negedge Clk);
  endtask

  task automatic leave();
    @(negedge Clk);
    EscMode = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({RecEn, RxLpdtEsc, RxUlpsEsc, RxTriggerEsc, RxDataEsc,
                 RxValidEsc, ErrEsc, ErrSyncEsc});
  endfunction

  typedef struct {
    logic [7:0] cmd;
    logic       lpdt;
    logic       ulps;
    logic [3:0] trig;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int v0, e0, s0, t0;
    vecs[0] = '{8'hE1, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{8'h1E, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[2] = '{8'h62, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[3] = '{8'h5D, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[4] = '{8'h21, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[5] = '{8'hA0, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[8] = '{8'hE0, 1'b0, 1'b0, 4'b0000, 1'b1};

    RstN = 1'b0;
    EscMode = 1'b1;
    RxClkEsc = 1'b0;
    EscBit = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", all_outs(), 0);
    EscMode = 1'b0;
    @(negedge Clk);
    RstN = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_outputs", all_outs(), 0);

    for (int i = 0; i < 9; i++) begin
      e0 = err_cnt; s0 = errsync_cnt; t0 = trig_cycles;
      trig_last = 4'b0000;
      enter(vecs[i].cmd);
      chk($sformatf("tbl%0d_lpdt", i), int'(RxLpdtEsc), int'(vecs[i].lpdt));
      chk($sformatf("tbl%0d_ulps", i), int'(RxUlpsEsc), int'(vecs[i].ulps));
      chk($sformatf("tbl%0d_trig_val", i), int'(trig_last), int'(vecs[i].trig));
      chk($sformatf("tbl%0d_trig_cycles", i), trig_cycles - t0, (vecs[i].trig != 4'b0000) ? 1 : 0);
      chk($sformatf("tbl%0d_err", i), err_cnt - e0, int'(vecs[i].err));
      leave();
      chk($sformatf("tbl%0d_exit_flags", i), int'({RxLpdtEsc, RxUlpsEsc}), 0);
      repeat (2) @(negedge Clk);
      chk($sformatf("tbl%0d_errsync", i), errsync_cnt - s0, 0);
    end

    // LPDT with two full bytes
    v0 = valid_cnt; s0 = errsync_cnt;
    enter(8'hE1);
    chk("lpdt_flag", int'(RxLpdtEsc), 1);
    send_lsb(8'h3C);
    send_lsb(8'hA5);
    repeat (6) @(negedge Clk);
    chk("lpdt_valid_cnt", valid_cnt - v0, 2);
    chk("lpdt_queue_empty", exp_q.size(), 0);
    chk("lpdt_data_hold", int'(RxDataEsc), 'hA5);
    leave();
    chk("lpdt_exit_flag", int'(RxLpdtEsc), 0);
    repeat (2) @(negedge Clk);
    chk("lpdt_full_byte_errsync", errsync_cnt - s0, 0);

    // ULPS ignores strobes
    v0 = valid_cnt; e0 = err_cnt; t0 = trig_cycles;
    enter(8'h1E);
    chk("ulps_flag", int'(RxUlpsEsc), 1);
    send_msb(8'hE1);
    repeat (3) @(negedge Clk);
    chk("ulps_hold", int'({RxLpdtEsc, RxUlpsEsc}), 1);
    chk("ulps_no_pulses", (valid_cnt - v0) + (err_cnt - e0) + (trig_cycles - t0), 0);
    leave();
    chk("ulps_exit_flags", int'({RxLpdtEsc, RxUlpsEsc, RxTriggerEsc, RxValidEsc, ErrEsc}), 0);

    // Trigger, then WAIT_EXIT ignores further bits
    repeat (3) @(negedge Clk);
    t0 = trig_cycles; e0 = err_cnt;
    enter(8'h62);
    chk("trig_wait_state", int'(dut.state_q == esc_pkg::ST_WAIT_EXIT), 1);
    chk("trig_once", trig_cycles - t0, 1);
    send_msb(8'hE1);
    repeat (3) @(negedge Clk);
    chk("wait_ignores_bits", int'({RxLpdtEsc, RxUlpsEsc}), 0);
    chk("wait_no_pulses", (trig_cycles - t0) + (err_cnt - e0), 1);
    leave();
    repeat (3) @(negedge Clk);

    // Partial LPDT byte on exit
    v0 = valid_cnt; s0 = errsync_cnt;
    enter(8'hE1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    repeat (3) @(negedge Clk);
    leave();
    repeat (3) @(negedge Clk);
    chk("partial_errsync", errsync_cnt - s0, 1);
    chk("partial_no_valid", valid_cnt - v0, 0);

    // Reset in the middle of an LPDT byte
    s0 = errsync_cnt;
    enter(8'hE1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge Clk);
    #3;
    RstN = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge Clk);
    EscMode = 1'b0;
    @(negedge Clk);
    RstN = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_no_errsync", errsync_cnt - s0, 0);
    enter(8'h1E);
    chk("post_reset_ulps", int'(RxUlpsEsc), 1);
    leave();
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
